// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 strand driver.
//   - tx_state_e     : frame sequencer states
//   - Def*           : default timing constants (clk cycles) and strand length
//   - scale_byte/grb : global brightness scaling and GRB byte reordering
package ws2812_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHigh,
        StLow,
        StGap
    } tx_state_e;

    localparam int unsigned DefNumLeds = 8;
    localparam int unsigned DefT0hCyc  = 14;
    localparam int unsigned DefT1hCyc  = 28;
    localparam int unsigned DefBitCyc  = 50;
    localparam int unsigned DefRstCyc  = 2000;

    // (c * (b + 1)) >> 8: b = 255 passes c through, b = 0 always gives 0.
    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = 17'(c) * (17'(b) + 17'd1);
        return 8'(prod >> 8);
    endfunction

    // Stored words are {R, G, B}; the strand expects G first, then R, then B.
    function automatic logic [23:0] scale_grb(input logic [23:0] rgb, input logic [7:0] b);
        return {scale_byte(rgb[15:8], b), scale_byte(rgb[23:16], b), scale_byte(rgb[7:0], b)};
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: generates one WS2812 bit waveform per start pulse.
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin a bit period on the next cycle (may coincide with done)
//   bit_val    : value of the bit being started
//   data       : registered serial output, high for T1H_CYC / T0H_CYC cycles
//   high_last  : current cycle is the last high cycle of the bit
//   done       : current cycle is the last cycle of the BIT_CYC period
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H_CYC = DefT0hCyc,
    parameter int unsigned T1H_CYC = DefT1hCyc,
    parameter int unsigned BIT_CYC = DefBitCyc
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic data,
    output logic high_last,
    output logic done
);

    localparam int unsigned CntW = $clog2(BIT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] len_q, len_d;
    logic [CntW-1:0] cnt_inc;
    logic            run_q, run_d;
    logic            data_q, data_d;

    assign cnt_inc   = cnt_q + CntW'(1);
    assign done      = run_q && (cnt_q == CntW'(BIT_CYC - 1));
    assign high_last = run_q && (cnt_inc == len_q);
    assign data      = data_q;

    always_comb begin
        cnt_d  = cnt_q;
        len_d  = len_q;
        run_d  = run_q;
        data_d = data_q;
        if (start) begin
            // Back-to-back bits: a start on the done cycle restarts seamlessly.
            cnt_d  = '0;
            len_d  = bit_val ? CntW'(T1H_CYC) : CntW'(T0H_CYC);
            run_d  = 1'b1;
            data_d = 1'b1;
        end else if (done) begin
            cnt_d  = '0;
            run_d  = 1'b0;
            data_d = 1'b0;
        end else if (run_q) begin
            cnt_d  = cnt_inc;
            data_d = (cnt_inc < len_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            len_q  <= '0;
            run_q  <= 1'b0;
            data_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            run_q  <= run_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/ws2812_chain.sv
// ws2812_chain: frame sequencer and colour memory for a WS2812 LED strand.
//   clk, reset    : clock, asynchronous active-high reset
//   led_num       : LED index for writes (out-of-range indices are ignored)
//   rgb_data      : colour {R, G, B} written when write = 1
//   write         : write strobe, accepted in any state
//   brightness    : global brightness, sampled once per frame
//   auto_refresh  : 1 = back-to-back frames, 0 = frames on refresh only
//   refresh       : start-frame pulse; latched as pending while busy
//   busy          : frame in progress (any state but idle)
//   frame_done    : one-cycle pulse on the last latch-gap cycle
//   data          : serial output to the strand
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = DefNumLeds,
    parameter int unsigned T0H_CYC  = DefT0hCyc,
    parameter int unsigned T1H_CYC  = DefT1hCyc,
    parameter int unsigned BIT_CYC  = DefBitCyc,
    parameter int unsigned RST_CYC  = DefRstCyc,
    localparam int unsigned ADDR_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] led_num,
    input  logic [23:0]       rgb_data,
    input  logic              write,
    input  logic [7:0]        brightness,
    input  logic              auto_refresh,
    input  logic              refresh,
    output logic              busy,
    output logic              frame_done,
    output logic              data
);

    localparam int unsigned GapW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    tx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] led_idx_q, led_idx_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]        bright_q, bright_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              tx_start, tx_bit, tx_high_last, tx_done;
    logic [23:0]       load_word;
    logic              wr_en;
    logic [23:0]       mem_q [NUM_LEDS];

    // Colour memory. The shift register holds its own copy, so a write to the
    // LED being shifted only shows up in the next frame.
    assign wr_en = write && (32'(led_num) < NUM_LEDS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[led_num] <= rgb_data;
        end
    end

    assign load_word = scale_grb(mem_q[led_idx_q], bright_q);

    ws2812_bit_tx #(
        .T0H_CYC(T0H_CYC),
        .T1H_CYC(T1H_CYC),
        .BIT_CYC(BIT_CYC)
    ) u_bit_tx (
        .clk      (clk),
        .reset    (reset),
        .start    (tx_start),
        .bit_val  (tx_bit),
        .data     (data),
        .high_last(tx_high_last),
        .done     (tx_done)
    );

    always_comb begin
        state_d   = state_q;
        led_idx_d = led_idx_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        gap_cnt_d = gap_cnt_q;
        bright_d  = bright_q;
        pend_d    = pend_q;
        tx_start  = 1'b0;
        tx_bit    = 1'b0;

        if (refresh && (state_q != StIdle)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (auto_refresh || refresh || pend_q) begin
                    state_d   = StLoad;
                    led_idx_d = '0;
                    bright_d  = brightness;
                    pend_d    = 1'b0;
                end
            end
            StLoad: begin
                // The first bit is taken straight from the scaled word.
                shift_d   = load_word;
                bit_cnt_d = '0;
                tx_start  = 1'b1;
                tx_bit    = load_word[23];
                state_d   = StHigh;
            end
            StHigh: begin
                if (tx_high_last) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (tx_done) begin
                    if (bit_cnt_q != 5'd23) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shift_d   = {shift_q[22:0], 1'b0};
                        tx_start  = 1'b1;
                        tx_bit    = shift_q[22];
                        state_d   = StHigh;
                    end else if (led_idx_q == ADDR_W'(NUM_LEDS - 1)) begin
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        led_idx_d = led_idx_q + ADDR_W'(1);
                        state_d   = StLoad;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(RST_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        busy_d       = (state_d != StIdle);
        frame_done_d = (state_d == StGap) && (gap_cnt_d == GapW'(RST_CYC - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            led_idx_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            gap_cnt_q    <= '0;
            bright_q     <= '0;
            pend_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            led_idx_q    <= led_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            gap_cnt_q    <= gap_cnt_d;
            bright_q     <= bright_d;
            pend_q       <= pend_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
